gate_test_sequencer: RTL and testbench

//  Self-test controller for a 2-input logic gate cell (NOR by default).

---
 rtl/gate_seq_pkg.sv | 13 +
 rtl/step_timer.sv | 28 ++
 rtl/gate_test_sequencer.sv | 111 +++++++++++
 tb/tb_gate_test_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the 2-input gate self-test sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  localparam int unsigned NUM_VEC = 4;

  // Expected gate output for vector index {b,a}.
  function automatic logic exp_bit(input logic [NUM_VEC-1:0] truth, input logic [1:0] idx);
    return truth[idx];
  endfunction

endpackage

// File: rtl/step_timer.sv
// Per-vector dwell counter: counts 0..STEP_CYCLES-1 while enabled and wraps.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [7:0] LastVal = 8'(STEP_CYCLES - 1);

  logic [7:0] count_q;

  assign last_o = (count_q == LastVal);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= last_o ? '0 : count_q + 8'd1;
    end
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Steps a 2-input gate through all four input vectors, checks its output against
// TRUTH and reports pass, per-vector fail mask and error count.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH       = 4'b0001,
  parameter int unsigned        STEP_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               c,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] fail_mask,
  output logic [2:0]         err_count,
  output logic [1:0]         vec_idx
);

  seq_state_t         state_q, state_d;
  logic [1:0]         vec_q, vec_d;
  logic [NUM_VEC-1:0] mask_q, mask_d;
  logic [2:0]         err_q, err_d;
  logic               pass_q, pass_d;
  logic               step_last;
  logic               start_ok;
  logic               mismatch;

  assign start_ok = (state_q == IDLE) && start && !abort;
  assign mismatch = (c != exp_bit(TRUTH, vec_q));

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_ok | abort),
    .en_i  (state_q == RUN),
    .last_o(step_last)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    err_d   = err_q;
    pass_d  = pass_q;
    // Abort wins over sampling; partial results are kept for inspection.
    if (abort) begin
      state_d = IDLE;
      vec_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d = RUN;
            vec_d   = '0;
            mask_d  = '0;
            err_d   = '0;
            pass_d  = 1'b0;
          end
        end
        RUN: begin
          if (step_last) begin
            if (mismatch) begin
              mask_d[vec_q] = 1'b1;
              err_d         = err_q + 3'd1;
            end
            vec_d = vec_q + 2'd1;
            if (vec_q == 2'(NUM_VEC - 1)) begin
              state_d = DONE;
              pass_d  = (err_d == 3'd0);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign a         = busy & vec_q[0];
  assign b         = busy & vec_q[1];
  assign vec_idx   = vec_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomized self-checking bench: two sequencer instances (NOR/5-cycle, AND/1-cycle)
// driving a tabulated gate model, compared cycle by cycle with a reference model.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_v = 1'b0;
  logic abort_v = 1'b0;
  logic sel = 1'b0;
  logic [3:0] gate_tbl = 4'b0001;

  logic a0, b0, busy0, done0, pass0, c0;
  logic a1, b1, busy1, done1, pass1, c1;
  logic [3:0] mask0, mask1;
  logic [2:0] err0, err1;
  logic [1:0] vec0, vec1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Gate under test: output looked up from a per-vector table indexed by {b,a}.
  assign c0 = gate_tbl[{b0, a0}];
  assign c1 = gate_tbl[{b1, a1}];

  gate_test_sequencer #(
    .TRUTH      (4'b0001),
    .STEP_CYCLES(5)
  ) dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start_v & ~sel),
    .abort    (abort_v & ~sel),
    .c        (c0),
    .a        (a0),
    .b        (b0),
    .busy     (busy0),
    .done     (done0),
    .pass     (pass0),
    .fail_mask(mask0),
    .err_count(err0),
    .vec_idx  (vec0)
  );

  gate_test_sequencer #(
    .TRUTH      (4'b1000),
    .STEP_CYCLES(1)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start_v & sel),
    .abort    (abort_v & sel),
    .c        (c1),
    .a        (a1),
    .b        (b1),
    .busy     (busy1),
    .done     (done1),
    .pass     (pass1),
    .fail_mask(mask1),
    .err_count(err1),
    .vec_idx  (vec1)
  );

  logic [13:0] pack0, pack1, obs;
  assign pack0 = {busy0, done0, a0, b0, vec0, pass0, mask0, err0};
  assign pack1 = {busy1, done1, a1, b1, vec1, pass1, mask1, err1};
  assign obs   = sel ? pack1 : pack0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {busy,done,a,b,vec,pass,mask,err} at cycle t after the accepted start.
  // Vector v is sampled at the end of cycle (v+1)*s; an abort raised during cycle
  // abort_t cancels every sample not yet taken.
  function automatic logic [13:0] model(input int t, input int s, input logic [3:0] truth,
                                        input logic [3:0] tbl, input int abort_t);
    bit aborted;
    int cutoff;
    int errs;
    logic [3:0] m;
    logic bsy, dn, ps;
    logic [1:0] vec;
    aborted = (abort_t > 0) && (abort_t < t);
    cutoff  = aborted ? abort_t : t;
    m = '0;
    errs = 0;
    for (int v = 0; v < 4; v++) begin
      if ((v + 1) * s < cutoff && tbl[v] !== truth[v]) begin
        m[v] = 1'b1;
        errs++;
      end
    end
    bsy = 1'b0;
    dn  = 1'b0;
    ps  = 1'b0;
    vec = 2'd0;
    if (!aborted) begin
      if (t <= 4 * s) begin
        bsy = 1'b1;
        vec = 2'((t - 1) / s);
      end else begin
        dn = (t == 4 * s + 1);
        ps = (errs == 0);
      end
    end
    return {bsy, dn, bsy & vec[0], bsy & vec[1], vec, ps, m, 3'(errs)};
  endfunction

  task automatic run_seq(input logic s1, input logic [3:0] tbl, input int abort_t,
                         input int restart_t);
    int steps;
    logic [3:0] truth;
    steps    = s1 ? 1 : 5;
    truth    = s1 ? 4'b1000 : 4'b0001;
    sel      = s1;
    gate_tbl = tbl;
    @(negedge clk);
    start_v = 1'b1;
    for (int t = 1; t <= 4 * steps + 2; t++) begin
      @(negedge clk);
      check_eq($sformatf("dut%0d tbl=%b ab=%0d rs=%0d t=%0d", s1, tbl, abort_t, restart_t, t),
               32'(obs), 32'(model(t, steps, truth, tbl, abort_t)));
      start_v = (t == restart_t);
      abort_v = (t == abort_t);
    end
    start_v = 1'b0;
    abort_v = 1'b0;
  endtask

  initial begin
    int ab;
    int rs;
    logic [3:0] tbl;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset dut0", 32'(pack0), 32'd0);
    check_eq("reset dut1", 32'(pack1), 32'd0);
    rst = 1'b0;

    run_seq(1'b0, 4'b0001, 0, 0);   // healthy NOR
    run_seq(1'b0, 4'b0000, 0, 0);   // stuck-at-0
    run_seq(1'b0, 4'b1111, 0, 0);   // stuck-at-1
    run_seq(1'b0, 4'b0001, 0, 7);   // spurious start in RUN
    run_seq(1'b0, 4'b0001, 12, 0);  // abort during vector 2
    run_seq(1'b0, 4'b0001, 0, 0);   // clean rerun after abort

    for (int i = 0; i < 10; i++) begin
      tbl = 4'($urandom);
      ab  = 0;
      rs  = 0;
      if ($urandom_range(2) == 0) ab = int'($urandom_range(20, 1));
      else if ($urandom_range(1) == 0) rs = int'($urandom_range(20, 1));
      run_seq(1'b0, tbl, ab, rs);
    end

    run_seq(1'b1, 4'b1000, 0, 0);   // AND gate, one cycle per vector
    for (int i = 0; i < 4; i++) begin
      run_seq(1'b1, 4'($urandom), 0, 0);
    end

    // Reset during RUN with a faulty gate so results are non-zero first.
    sel      = 1'b1;
    gate_tbl = 4'b0111;
    @(negedge clk);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    @(negedge clk);
    check_eq("dut1 mid-run before rst", 32'(pack1), 32'(model(2, 1, 4'b1000, 4'b0111, 0)));
    rst = 1'b1;
    @(negedge clk);
    check_eq("dut1 after rst", 32'(pack1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("dut1 idle after rst", 32'(pack1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
